// File: rtl/hex_scan_scheduler.sv
`default_nettype none
// ============================================================================
// hex_scan_scheduler : round-robin nibble writers feeding one time-shared
//                      7-segment decoder that scans HEX0..HEX3
// Revision: 1.0
// ============================================================================
module hex_scan_scheduler #(
  parameter int CLK_DIV = 50000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [15:0] wdata,
  input  logic [3:0]  blank,
  output logic [3:0]  ack,
  output logic [0:6]  HEX0,
  output logic [0:6]  HEX1,
  output logic [0:6]  HEX2,
  output logic [0:6]  HEX3,
  output logic [1:0]  scan_slot
);

  localparam int              c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_DIV - 1);
  localparam logic [6:0]      c_DARK  = 7'b1111111;

  logic [3:0]         r_digit [4];
  logic [6:0]         r_hex   [4];
  logic [3:0]         r_ack;
  logic [1:0]         r_ptr;
  logic [1:0]         r_slot;
  logic [c_CNT_W-1:0] r_cnt;

  logic [3:0] w_elig;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_any;
  logic       w_tick;
  logic [6:0] w_dec;
  logic [6:0] w_seg;

  // Segment patterns are written a..g left to right, active low.
  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b1110010;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Masking by the live ack keeps a requester that drops one cycle late from a second grant.
  assign w_elig = req & ~r_ack;

  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_any && w_elig[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_tick = (r_cnt == c_LAST);
  assign w_dec  = f_decode(r_digit[r_slot]);
  assign w_seg  = blank[r_slot] ? c_DARK : w_dec;

  // Scan reads r_digit before this edge's write lands, so a same-edge write shows next visit.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        r_digit[i] <= 4'h0;
        r_hex[i]   <= c_DARK;
      end
      r_ack  <= 4'b0000;
      r_ptr  <= 2'd0;
      r_slot <= 2'd0;
      r_cnt  <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
      if (w_tick) begin
        r_hex[r_slot] <= w_seg;
        r_slot        <= r_slot + 2'd1;
      end
      r_ack <= w_any ? (4'b0001 << w_win) : 4'b0000;
      if (w_any) begin
        r_digit[w_win] <= wdata[{w_win, 2'b00} +: 4];
        r_ptr          <= w_win + 2'd1;
      end
    end
  end

  assign ack       = r_ack;
  assign scan_slot = r_slot;
  assign HEX0      = r_hex[0];
  assign HEX1      = r_hex[1];
  assign HEX2      = r_hex[2];
  assign HEX3      = r_hex[3];

endmodule
`default_nettype wire

// File: doc/hex_scan_scheduler.md
# hex_scan_scheduler

Shares one 4-bit-to-7-segment decode path among four independent writers and sequences it across the board's four digits HEX0..HEX3. The block contains:
- a round-robin arbiter with a req/ack handshake that loads each writer's nibble into a digit register;
- a prescaled scan sequencer that steps the shared decoder through the digit slots and registers each result into its HEX output.

It sits between the switch/logic sources at top level and the HEX pins.

## Interface
- CLK_DIV, default 50000: scan prescaler period in clock cycles. Legal range is 1..2^20. A value of 1 produces a tick every cycle.
- CLOCK_50  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- req  input  4  write request per writer i; held high until ack[i] is seen
- wdata  input  16  nibble for writer i on wdata[4i+3:4i]; must be stable while req[i] is high
- blank  input  4  blank[i]=1 forces digit i dark at its next scan update
- ack  output  4  one-cycle registered grant pulse, one-hot or zero
- HEX0, HEX1, HEX2, HEX3  output  7 each, declared [0:6]  registered active-low segments, bit 0 = segment a
- scan_slot  output  2  slot currently being decoded

## Operation
- **Reset values:** digit registers 4'h0, HEX0..HEX3 7'b1111111 (dark), ack 4'b0000, round-robin pointer 0, scan_slot 0, prescaler 0.
- **Arbitration (every cycle):**
  - eligible = req & ~ack. A writer whose ack is currently high is masked, so a requester that drops req one cycle after ack is never double-granted.
  - The winner is the first eligible index searching from the pointer upward, mod 4.
  - On the edge: digit_reg[winner] <= wdata nibble of the winner, ack <= one-hot(winner), pointer <= winner+1 mod 4.
  - If nothing is eligible: ack <= 0 and the pointer holds.
- **Handshake:** a requester may drop req any time after seeing ack. A req still high after the masking cycle is treated as a new request.
- **Prescaler:** counts 0..CLK_DIV-1. tick = (count == CLK_DIV-1).
- **Scan:** on tick, HEX[scan_slot] <= blank[scan_slot] ? 7'b1111111 : decode(digit_reg[scan_slot]), then scan_slot <= scan_slot+1. 3 wraps to 0. The other HEX outputs hold.
- **Decode, 0..F in order:**
  - 0–7: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111
  - 8–F: 0000000, 0000100, 0001000, 1100000, 1110010, 1000010, 0110000, 0111000
  - There is exactly one decoder instance, muxed by scan_slot.
- **Simultaneous write and scan of the same digit on one edge:** the scan uses the pre-write register value. The new value appears on that digit's next visit.
- **blank changes** take effect only at that slot's next tick. There is no immediate forcing.
- **Reset mid-operation:** all state and outputs return to reset values immediately. Any in-flight request must be re-issued after release.

## Timing
- ack latency: req[i] high and winning at edge k gives ack[i]=1 during cycle k..k+1, exactly one cycle.
- Under full load all four requesters are granted within 4 consecutive cycles. Worst-case wait for any requester is 3 cycles.
- Write-to-display latency is between 1 and 4·CLK_DIV cycles after the ack edge, plus the same-edge case above.
- Each digit refreshes once per 4·CLK_DIV cycles.
- All outputs are registered. No combinational path from req/wdata/blank to any output.
- resetn is asynchronous assert. Deassert is assumed synchronized externally.

## Test plan
1. **Reset:** hold resetn=0 with random inputs. Require HEX0..3=7'b1111111, ack=0, scan_slot=0. Then release with no req and CLK_DIV=4: after 16 cycles all HEX=7'b0000001 (digit 0).
2. **Single write:** with CLK_DIV=4, req[2]=1 and wdata[11:8]=4'hA.
   - Require ack=4'b0100 for exactly one cycle, then no further ack while req stays high only through the masking cycle.
   - Within 16 cycles HEX2=7'b0001000; HEX0/1/3 unchanged.
3. **Full contention:** req=4'b1111 from pointer 0, each dropped one cycle after its ack, with nibbles 8,F,3,C.
   - Require acks 0001, 0010, 0100, 1000 on consecutive cycles.
   - After one scan round: HEX0=0000000, HEX1=0111000, HEX2=0000110, HEX3=1110010.
4. **Fairness:** req[0] and req[1] held high continuously. Require grants to alternate 0,1,0,1 with no ack to 2 or 3 and no back-to-back grant to one index.
5. **Blank:** blank=4'b0010 with digit1=5.
   - Require HEX1=7'b1111111 from the next slot-1 tick.
   - After clearing blank, HEX1=7'b0100100 at the following slot-1 tick.
6. **Mid-operation reset:** pulse resetn low during an ack cycle and mid-scan. Require immediate reset values on all outputs, and that the digit previously written reads 0 after release.
